jpeg_dezigzag_dequant: RTL and testbench
========================================

Name: jpeg_dezigzag_dequant

Overview:
- Upstream neighbour of the 1-D IDCT.
- Accepts Huffman-decoded DCT coefficients in zigzag order, one per beat, and multiplies each by its quantisation table entry.
- Scatters each product into natural (row-major) order in a ping-pong 8x8 buffer.
- Delivers each finished block as 8 rows of 8 signed 32-bit values, the form the IDCT's in0..in7 expect.

Parameters:
- COEF_W, 16, signed input coefficient width.
- Q_W, 8, unsigned quantisation entry width.
- OUT_W, 32, signed output element width; must be >= COEF_W+Q_W+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- qt_wr_en  in  1  quant table write strobe.
- qt_wr_addr  in  6  table index, zigzag order.
- qt_wr_data  in  Q_W  table value.
- coef_valid  in  1  coefficient beat valid.
- coef_ready  out  1  block can accept a beat.
- coef_data  in  COEF_W  signed coefficient.
- coef_eob  in  1  this beat is the last explicit coefficient; all remaining positions are zero.
- row_valid  out  1  output row valid.
- row_ready  in  1  downstream accepts the row.
- row_data  out  8*OUT_W  row elements; element k is at bits [k*OUT_W +: OUT_W] and maps to IDCT in_k.
- row_idx  out  3  row number 0..7.
- row_last  out  1  row_idx==7.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - coef_ready=1, row_valid=0, row_idx=0, row_last=0, row_data=0.
  - Both banks FREE, write bank=0, read bank=0, zigzag counter=0.
  - Every quant entry reset to 1 (identity dequant).
- Quant table:
  - 64 x Q_W registers, written on qt_wr_en. A write is visible from the next cycle.
  - If a write and a coefficient beat hit the same index in one cycle, the beat uses the old value.
  - The table may only be rewritten between frames; nothing in the block enforces this.
- Banks:
  - Two 64-entry banks, each holding OUT_W-bit data, a 64-bit written mask, and a state FREE or FULL.
- Fill side:
  - coef_ready = (write bank FREE).
  - A beat is accepted when coef_valid && coef_ready, at zigzag index zz = counter.
  - On accept: bank[nat(zz)] <= sext(coef_data) * zext(q[zz]), computed as a signed multiply at full width and then sign-extended to OUT_W. The mask bit nat(zz) is set.
  - If zz==63 or coef_eob: the bank becomes FULL, the write bank toggles and the counter resets to 0. Otherwise the counter increments.
  - Starting a new block in a bank clears its mask. Clearing happens when the bank is released by the read side.
  - Positions with mask=0 read as 0, so an eob beat at zz=0 gives a DC-only block.
  - coef_eob at zz==63 is redundant and is not an error.
- Read side:
  - row_valid = (read bank FULL).
  - row_data is combinational from the read bank at row row_idx, with masked zeros applied.
  - On row_valid && row_ready: row_idx increments.
  - If row_idx==7: the bank becomes FREE, its mask is cleared, the read bank toggles and row_idx returns to 0.
  - row_data, row_idx and row_last must hold stable while row_valid && !row_ready.
- Latency and throughput:
  - A beat that fills a bank at cycle N gives row_valid=1 at cycle N+1, provided that bank is the read bank.
  - Sustained rate: one block per 64 input cycles. Output drains in 8 cycles when row_ready=1.
- Simultaneous events:
  - Fill-complete on one bank and release on the other in the same cycle are both honoured.
  - When both banks are FULL, coef_ready=0 and input stalls with no loss.
  - A release in cycle N makes coef_ready=1 in cycle N+1.
- Reset mid-operation: the partial block and both stored blocks are discarded, and the quant table returns to all 1s.
- Arithmetic: there is no saturation. OUT_W >= COEF_W+Q_W+1 guarantees there is no overflow.

Decomposition:
- Shared package jpeg_pkg holds:
  - the zigzag-to-natural index table ZZ2NAT[64] (0,1,8,16,9,2,3,10,...,63) as a constant or function;
  - the bank state encoding FREE/FULL;
  - BLK_SIZE=64 and ROW_LEN=8.
- One sub-module: jpeg_zigzag_lut, a combinational 6-bit zz to 6-bit natural-index ROM built from ZZ2NAT. It is reused by the encoder-side test models.

Test Plan:
- Identity block: qt all 1, feed coef=zz (0..63) with row_ready=1.
  - Row 0 must be {0,1,5,6,14,15,27,28}.
  - Row 7 must be {35,36,48,49,57,58,62,63}.
  - row_last must be high only on row 7.
- Dequant and sign: load q[zz]=2 for all zz, feed coef_data=-3 at zz=0 with coef_eob=1.
  - Row 0 element 0 must be -6. All other 63 outputs must be 0.
  - coef_ready must stay high.
- Back-pressure ping-pong: hold row_ready=0 and stream two full blocks.
  - coef_ready must drop after the 128th accepted beat.
  - The third block must stall until 8 rows are drained.
  - Data must not be corrupted or reordered.
- Mask clearing: send a full block of 7s, drain it, then send block 2 whose zz=0 beat is coef=1 with eob.
  - Block 2 must output 1 followed by 63 zeros, with no stale 7s.
- Reset mid-block: accept 30 beats, assert rst for one cycle, then send a fresh DC-only block with coef=5.
  - Output must be exactly one block: 5 followed by zeros.
  - row_valid must stay low before that block completes.
- Quant write collision: write q[0]=4 in the same cycle the zz=0 beat coef=10 is accepted, with old q=1.
  - Output must be 10. The next block's DC with coef=10 must give 40.

Source files
------------

// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
// jpeg_pkg : shared zigzag table, block geometry and bank state encoding
// Revision : 1.0
// ============================================================================
package jpeg_pkg;

    localparam int BLK_SIZE = 64;
    localparam int ROW_LEN  = 8;

    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_t;

    // Natural (row-major) position of each zigzag-ordered coefficient.
    localparam logic [5:0] ZZ2NAT [BLK_SIZE] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    function automatic logic [5:0] zz2nat(input logic [5:0] zz);
        return ZZ2NAT[zz];
    endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_dezigzag_dequant_if.sv
`default_nettype none
// ============================================================================
// jpeg_dezigzag_dequant_if : quant-table write, coefficient and row channels
// Revision : 1.0
// ============================================================================
interface jpeg_dezigzag_dequant_if
    import jpeg_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int Q_W    = 8,
    parameter int OUT_W  = 32
);
    logic                      qt_wr_en;
    logic [5:0]                qt_wr_addr;
    logic [Q_W-1:0]            qt_wr_data;

    logic                      coef_valid;
    logic                      coef_ready;
    logic [COEF_W-1:0]         coef_data;
    logic                      coef_eob;

    logic                      row_valid;
    logic                      row_ready;
    logic [ROW_LEN*OUT_W-1:0]  row_data;
    logic [2:0]                row_idx;
    logic                      row_last;

    modport master (
        output qt_wr_en, qt_wr_addr, qt_wr_data,
        output coef_valid, coef_data, coef_eob,
        input  coef_ready,
        input  row_valid, row_data, row_idx, row_last,
        output row_ready
    );

    modport slave (
        input  qt_wr_en, qt_wr_addr, qt_wr_data,
        input  coef_valid, coef_data, coef_eob,
        output coef_ready,
        output row_valid, row_data, row_idx, row_last,
        input  row_ready
    );
endinterface
`default_nettype wire

// File: rtl/jpeg_zigzag_lut.sv
`default_nettype none
// ============================================================================
// jpeg_zigzag_lut : combinational zigzag index to natural index ROM
// Revision : 1.0
// ============================================================================
module jpeg_zigzag_lut
    import jpeg_pkg::*;
(
    input  wire logic [5:0] zz,
    output logic      [5:0] nat
);
    assign nat = zz2nat(zz);
endmodule
`default_nettype wire

// File: rtl/jpeg_dezigzag_dequant.sv
`default_nettype none
// ============================================================================
// jpeg_dezigzag_dequant : dequantise zigzag coefficients into a ping-pong
//                         8x8 buffer and emit natural-order rows
// Revision : 1.0
// ============================================================================
module jpeg_dezigzag_dequant
    import jpeg_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int Q_W    = 8,
    parameter int OUT_W  = 32
)(
    input  wire logic               clk,
    input  wire logic               rst,
    jpeg_dezigzag_dequant_if.slave  bus
);

    logic [Q_W-1:0]           r_qt    [BLK_SIZE];
    logic [OUT_W-1:0]         r_data  [2][BLK_SIZE];
    logic [BLK_SIZE-1:0]      r_mask  [2];
    bank_state_t              r_state [2];
    bank_state_t              w_state_nxt [2];
    logic                     r_wr_bank, w_wr_bank_nxt;
    logic                     r_rd_bank, w_rd_bank_nxt;
    logic [5:0]               r_zz, w_zz_nxt;
    logic [2:0]               r_row_idx, w_row_idx_nxt;

    logic [5:0]               w_nat;
    logic                     w_accept;
    logic                     w_fill_done;
    logic                     w_pop;
    logic                     w_release;
    logic signed [OUT_W-1:0]  w_coef_s;
    logic signed [OUT_W-1:0]  w_q_s;
    logic signed [OUT_W-1:0]  w_prod;
    logic [ROW_LEN*OUT_W-1:0] w_row_data;

    jpeg_zigzag_lut u_zigzag_lut (
        .zz  (r_zz),
        .nat (w_nat)
    );

    assign bus.coef_ready = (r_state[r_wr_bank] == BANK_FREE);
    assign bus.row_valid  = (r_state[r_rd_bank] == BANK_FULL);

    assign w_accept    = bus.coef_valid && bus.coef_ready;
    assign w_fill_done = w_accept && ((r_zz == 6'(BLK_SIZE - 1)) || bus.coef_eob);
    assign w_pop       = bus.row_valid && bus.row_ready;
    assign w_release   = w_pop && (r_row_idx == 3'(ROW_LEN - 1));

    // Operands widened to OUT_W first, so the product is exact without saturation.
    assign w_coef_s = OUT_W'($signed(bus.coef_data));
    assign w_q_s    = {{(OUT_W - Q_W){1'b0}}, r_qt[r_zz]};
    assign w_prod   = w_coef_s * w_q_s;

    always_comb begin
        w_state_nxt[0] = r_state[0];
        w_state_nxt[1] = r_state[1];
        w_wr_bank_nxt  = r_wr_bank;
        w_rd_bank_nxt  = r_rd_bank;
        w_zz_nxt       = r_zz;
        w_row_idx_nxt  = r_row_idx;

        if (w_accept) begin
            w_zz_nxt = w_fill_done ? 6'd0 : r_zz + 6'd1;
        end
        if (w_fill_done) begin
            w_state_nxt[r_wr_bank] = BANK_FULL;
            w_wr_bank_nxt          = ~r_wr_bank;
        end
        if (w_pop) begin
            w_row_idx_nxt = r_row_idx + 3'd1;
        end
        // A bank being filled is FREE and a bank being released is FULL, so
        // these two updates never target the same bank.
        if (w_release) begin
            w_state_nxt[r_rd_bank] = BANK_FREE;
            w_rd_bank_nxt          = ~r_rd_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state[0] <= BANK_FREE;
            r_state[1] <= BANK_FREE;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_zz       <= 6'd0;
            r_row_idx  <= 3'd0;
            r_mask[0]  <= '0;
            r_mask[1]  <= '0;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
            r_wr_bank  <= w_wr_bank_nxt;
            r_rd_bank  <= w_rd_bank_nxt;
            r_zz       <= w_zz_nxt;
            r_row_idx  <= w_row_idx_nxt;
            if (w_accept) begin
                r_mask[r_wr_bank][w_nat] <= 1'b1;
            end
            if (w_release) begin
                r_mask[r_rd_bank] <= '0;
            end
        end
    end

    // A beat reads r_qt before a same-cycle write lands, so it sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BLK_SIZE; i++) begin
                r_qt[i] <= Q_W'(1);
            end
        end else if (bus.qt_wr_en) begin
            r_qt[bus.qt_wr_addr] <= bus.qt_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data[r_wr_bank][w_nat] <= w_prod;
        end
    end

    for (genvar k = 0; k < ROW_LEN; k++) begin : g_row_elem
        logic [5:0] w_idx;
        assign w_idx = {r_row_idx, 3'(k)};
        assign w_row_data[k*OUT_W +: OUT_W] =
            r_mask[r_rd_bank][w_idx] ? r_data[r_rd_bank][w_idx] : '0;
    end

    assign bus.row_data = w_row_data;
    assign bus.row_idx  = r_row_idx;
    assign bus.row_last = (r_row_idx == 3'(ROW_LEN - 1));

endmodule
`default_nettype wire

// File: tb/tb_jpeg_dezigzag_dequant.sv
`default_nettype none
// ============================================================================
// tb_jpeg_dezigzag_dequant : directed and randomized checks against a
//                            diagonal-walk reference model
// Revision : 1.0
// ============================================================================
module tb_jpeg_dezigzag_dequant;
    import jpeg_pkg::*;

    localparam int COEF_W = 16;
    localparam int Q_W    = 8;
    localparam int OUT_W  = 32;

    typedef struct {
        int coef;
        bit eob;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jpeg_dezigzag_dequant_if #(.COEF_W(COEF_W), .Q_W(Q_W), .OUT_W(OUT_W)) bus ();

    jpeg_dezigzag_dequant #(.COEF_W(COEF_W), .Q_W(Q_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    zz_nat [64];
    int    model_q [64];
    int    cur [64];
    int    zz_cnt;
    int    row_cnt;
    int    exp_q [$];
    beat_t beats [$];
    int    accepted = 0;
    bit    hold_prev;
    logic [8*OUT_W-1:0] hold_data;
    logic [2:0]         hold_idx;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Zigzag order by walking the anti-diagonals of the 8x8 block.
    function automatic void build_zigzag();
        int n;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo, hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin zz_nat[n] = r * 8 + (s - r); n++; end
            end else begin
                for (int r = hi; r >= lo; r--) begin zz_nat[n] = r * 8 + (s - r); n++; end
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin model_q[i] = 1; cur[i] = 0; end
        zz_cnt = 0; row_cnt = 0; hold_prev = 0;
        exp_q.delete(); beats.delete();
    endfunction

    task automatic check_row();
        if (exp_q.size() < 8) begin
            check("row_unexpected", exp_q.size(), 8);
        end else begin
            for (int k = 0; k < 8; k++) begin
                check("row_elem", $signed(bus.row_data[k*OUT_W +: OUT_W]), exp_q[k]);
            end
            check("row_idx", bus.row_idx, row_cnt);
            check("row_last", bus.row_last, (row_cnt == 7) ? 1 : 0);
            repeat (8) void'(exp_q.pop_front());
            row_cnt = (row_cnt + 1) % 8;
        end
    endtask

    task automatic tick(input int mode);
        int held;
        bus.row_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        if (beats.size() > 0) begin
            bus.coef_valid = 1'b1;
            bus.coef_data  = COEF_W'(beats[0].coef);
            bus.coef_eob   = beats[0].eob;
        end else begin
            bus.coef_valid = 1'b0;
            bus.coef_data  = COEF_W'($urandom);
            bus.coef_eob   = 1'b0;
        end
        @(negedge clk);
        held = (exp_q.size() + 63) / 64;
        check("coef_ready", bus.coef_ready, (held < 2) ? 1 : 0);
        check("row_valid", bus.row_valid, (held > 0) ? 1 : 0);
        if (hold_prev && bus.row_valid) begin
            check("hold_data", (bus.row_data === hold_data) ? 1 : 0, 1);
            check("hold_idx", bus.row_idx, hold_idx);
        end
        hold_prev = bus.row_valid && !bus.row_ready;
        hold_data = bus.row_data;
        hold_idx  = bus.row_idx;
        if (bus.row_valid && bus.row_ready) check_row();
        if (bus.coef_valid && bus.coef_ready) begin
            cur[zz_nat[zz_cnt]] = beats[0].coef * model_q[zz_cnt];
            if (zz_cnt == 63 || beats[0].eob) begin
                for (int i = 0; i < 64; i++) begin exp_q.push_back(cur[i]); cur[i] = 0; end
                zz_cnt = 0;
            end else begin
                zz_cnt++;
            end
            void'(beats.pop_front());
            accepted++;
        end
        if (bus.qt_wr_en) model_q[bus.qt_wr_addr] = int'(bus.qt_wr_data);
        @(posedge clk);
        #1;
        bus.qt_wr_en = 1'b0;
    endtask

    task automatic run(input int mode, input int max_cycles);
        int n;
        n = 0;
        while ((beats.size() > 0 || exp_q.size() > 0) && n < max_cycles) begin
            tick(mode);
            n++;
        end
        check("run_timeout", beats.size() + exp_q.size(), 0);
    endtask

    task automatic run_n(input int mode, input int n);
        repeat (n) tick(mode);
    endtask

    task automatic qt_write(input int addr, input int val);
        bus.qt_wr_en   = 1'b1;
        bus.qt_wr_addr = 6'(addr);
        bus.qt_wr_data = Q_W'(val);
        tick(0);
    endtask

    task automatic do_reset();
        bus.coef_valid = 1'b0;
        bus.qt_wr_en   = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        check("rst_coef_ready", bus.coef_ready, 1);
        check("rst_row_valid", bus.row_valid, 0);
        check("rst_row_idx", bus.row_idx, 0);
        check("rst_row_last", bus.row_last, 0);
        check("rst_row_data", |bus.row_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic push_block(input int len, input bit eob_last, input bit rand_coef, input int val);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.coef = rand_coef ? int'($urandom_range(0, 65535)) - 32768 : val;
            b.eob  = (i == len - 1) ? eob_last : 1'b0;
            beats.push_back(b);
        end
    endtask

    initial begin
        beat_t b;
        int    acc0;
        bus.qt_wr_en = 1'b0; bus.qt_wr_addr = '0; bus.qt_wr_data = '0;
        bus.coef_valid = 1'b0; bus.coef_data = '0; bus.coef_eob = 1'b0;
        bus.row_ready = 1'b0;
        rst = 1'b0;
        build_zigzag();
        model_reset();
        do_reset();

        // Identity block: coefficient value equals its zigzag index.
        for (int i = 0; i < 64; i++) begin b.coef = i; b.eob = 0; beats.push_back(b); end
        run(0, 300);

        // Dequant and sign with q = 2 everywhere, DC-only block.
        for (int i = 0; i < 64; i++) qt_write(i, 2);
        b.coef = -3; b.eob = 1; beats.push_back(b);
        run(0, 100);

        // Back-pressure ping-pong with a random table and random data.
        do_reset();
        for (int i = 0; i < 64; i++) qt_write(i, int'($urandom_range(0, 255)));
        repeat (3) push_block(64, 1'b0, 1'b1, 0);
        acc0 = accepted;
        run_n(1, 200);
        check("bp_accepted", accepted - acc0, 128);
        check("bp_pending", beats.size(), 64);
        run(0, 600);

        // Random block lengths with early eob and random downstream stalls.
        push_block(64, 1'b1, 1'b1, 0);
        repeat (4) push_block(int'($urandom_range(1, 64)), 1'b1, 1'b1, 0);
        run(2, 3000);

        // Mask clearing: full block of 7s, then a DC-only block of 1.
        do_reset();
        push_block(64, 1'b0, 1'b0, 7);
        run(0, 300);
        push_block(1, 1'b1, 1'b0, 1);
        run(0, 100);

        // Reset in the middle of a block.
        push_block(64, 1'b0, 1'b1, 0);
        acc0 = accepted;
        run_n(0, 30);
        check("mid_accepted", accepted - acc0, 30);
        do_reset();
        push_block(1, 1'b1, 1'b0, 5);
        run(0, 100);

        // Quant write colliding with the zz=0 beat.
        b.coef = 10; b.eob = 1; beats.push_back(b);
        bus.qt_wr_en = 1'b1; bus.qt_wr_addr = 6'd0; bus.qt_wr_data = Q_W'(4);
        tick(0);
        run(0, 100);
        b.coef = 10; b.eob = 1; beats.push_back(b);
        run(0, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
